// File: rtl/traffic_light_controller.sv
// traffic_light_controller: main/side road light sequencer with pedestrian crossing of the main road.
// Optional `TLC_PED_COUNTDOWN_EN adds a walk_count output with the remaining walk+clear seconds.
module traffic_light_controller #(
  parameter int TICK_DIV   = 27000000,
  parameter int MIN_MAIN_T = 10,
  parameter int YELLOW_T   = 3,
  parameter int ALLRED_T   = 1,
  parameter int SIDE_T     = 6,
  parameter int WALK_T     = 8,
  parameter int CLEAR_T    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       side_req,
  input  logic       ped_req,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk,
  output logic       side_pending,
  output logic       ped_pending,
  output logic [2:0] phase
`ifdef TLC_PED_COUNTDOWN_EN
  , output logic [7:0] walk_count
`endif
);
  localparam int PW = $clog2(TICK_DIV + 1);
  typedef enum logic [2:0] {
    MAIN_GREEN, MAIN_YELLOW, ALLRED_A, SIDE_GREEN, SIDE_YELLOW, ALLRED_B, PED_WALK, PED_CLEAR
  } state_t;
  state_t state, nxt;
  logic [PW-1:0] presc, presc_n;
  logic [7:0] secs, secs_n;
  logic side_q, ped_q, min_done, tick, expire, min_now, entry, hold;
  int dur;
  assign phase = state;
  assign tick = presc == PW'(TICK_DIV - 1);
  assign dur = (state == MAIN_YELLOW || state == SIDE_YELLOW) ? YELLOW_T :
               (state == ALLRED_A || state == ALLRED_B) ? ALLRED_T :
               state == SIDE_GREEN ? SIDE_T :
               state == PED_WALK ? WALK_T :
               state == PED_CLEAR ? CLEAR_T : MIN_MAIN_T;
  assign expire = tick && secs == 8'(dur - 1);
  assign min_now = min_done || expire;
  // once the minimum green is met with nothing waiting, freeze the counters
  assign hold = state == MAIN_GREEN && min_done;
  always_comb begin
    nxt = state;
    unique case (state)
      MAIN_GREEN:  nxt = (min_now && (side_pending || ped_pending)) ? MAIN_YELLOW : MAIN_GREEN;
      MAIN_YELLOW: nxt = expire ? ALLRED_A : state;
      ALLRED_A:    nxt = expire ? (side_pending ? SIDE_GREEN : PED_WALK) : state;
      SIDE_GREEN:  nxt = expire ? SIDE_YELLOW : state;
      SIDE_YELLOW: nxt = expire ? ALLRED_B : state;
      ALLRED_B:    nxt = expire ? (ped_pending ? PED_WALK : MAIN_GREEN) : state;
      PED_WALK:    nxt = expire ? PED_CLEAR : state;
      PED_CLEAR:   nxt = expire ? MAIN_GREEN : state;
    endcase
  end
  assign entry = nxt != state;
  assign presc_n = entry ? '0 : hold ? presc : tick ? '0 : presc + PW'(1);
  assign secs_n = entry ? 8'd0 : hold ? secs : tick ? secs + 8'd1 : secs;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= MAIN_GREEN;
      main_light   <= 3'b001;
      side_light   <= 3'b100;
      walk         <= 1'b0;
      side_pending <= 1'b0;
      ped_pending  <= 1'b0;
      presc        <= '0;
      secs         <= 8'd0;
      min_done     <= 1'b0;
      side_q       <= side_req;
      ped_q        <= ped_req;
    end else begin
      state        <= nxt;
      main_light   <= nxt == MAIN_GREEN ? 3'b001 : nxt == MAIN_YELLOW ? 3'b010 : 3'b100;
      side_light   <= nxt == SIDE_GREEN ? 3'b001 : nxt == SIDE_YELLOW ? 3'b010 : 3'b100;
      walk         <= nxt == PED_WALK || (nxt == PED_CLEAR && !secs_n[0]);
      side_pending <= (side_req && !side_q) || (side_pending && !(entry && nxt == SIDE_GREEN));
      ped_pending  <= (ped_req && !ped_q) || (ped_pending && !(entry && nxt == PED_WALK));
      presc        <= presc_n;
      secs         <= secs_n;
      min_done     <= state == MAIN_GREEN && !entry && min_now;
      side_q       <= side_req;
      ped_q        <= ped_req;
    end
  end
`ifdef TLC_PED_COUNTDOWN_EN
  always_ff @(posedge clk) begin
    if (!reset) walk_count <= 8'd0;
    else walk_count <= !(nxt == PED_WALK || nxt == PED_CLEAR) ? 8'd0 :
                       (entry && nxt == PED_WALK) ? 8'(WALK_T + CLEAR_T) :
                       tick ? walk_count - 8'd1 : walk_count;
  end
`endif
endmodule

// File: tb/tb_traffic_light_controller.sv
// tb_traffic_light_controller: directed checks of the light sequence with shortened timing.
module tb_traffic_light_controller;
  logic clk = 1'b0, reset = 1'b0, side_req = 1'b0, ped_req = 1'b0;
  logic [2:0] main_light, side_light, phase;
  logic walk, side_pending, ped_pending;
`ifdef TLC_PED_COUNTDOWN_EN
  logic [7:0] walk_count;
`endif
  int checks = 0, errors = 0;
  traffic_light_controller #(
    .TICK_DIV(4), .MIN_MAIN_T(4), .YELLOW_T(2), .ALLRED_T(1), .SIDE_T(3), .WALK_T(2), .CLEAR_T(2)
  ) dut (
    .clk(clk), .reset(reset), .side_req(side_req), .ped_req(ped_req),
    .main_light(main_light), .side_light(side_light), .walk(walk),
    .side_pending(side_pending), .ped_pending(ped_pending), .phase(phase)
`ifdef TLC_PED_COUNTDOWN_EN
    , .walk_count(walk_count)
`endif
  );
  always #5 clk = ~clk;
  function automatic logic [9:0] expect_out(input logic [2:0] p, input logic w);
    logic [2:0] m, s;
    m = p == 3'd0 ? 3'b001 : p == 3'd1 ? 3'b010 : 3'b100;
    s = p == 3'd3 ? 3'b001 : p == 3'd4 ? 3'b010 : 3'b100;
    return {p, m, s, w};
  endfunction
  always @(negedge clk) begin
    if (reset) begin
      checks++;
      if ((main_light != 3'b100 && side_light != 3'b100) || (walk && (main_light != 3'b100 || side_light != 3'b100))) begin
        errors++;
        $display("FAIL safety: main=%b side=%b walk=%b", main_light, side_light, walk);
      end
    end
  end
  task automatic do_reset(input logic ped_hold);
    @(negedge clk);
    reset = 1'b0;
    side_req = 1'b0;
    ped_req = ped_hold;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask
  task automatic test_reset_idle;
    do_reset(1'b0);
    checks++;
    if ({side_pending, ped_pending} !== 2'b00) begin
      errors++;
      $display("FAIL reset_pending: got %b want 00", {side_pending, ped_pending});
    end
`ifdef TLC_PED_COUNTDOWN_EN
    checks++;
    if (walk_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_walk_count: got %0d want 0", walk_count);
    end
`endif
    for (int c = 0; c < 200; c++) begin
      checks++;
      if ({phase, main_light, side_light, walk} !== 10'b000_001_100_0) begin
        errors++;
        $display("FAIL idle c=%0d: got %b want 0000011000", c, {phase, main_light, side_light, walk});
      end
      @(negedge clk);
    end
  endtask
  task automatic test_side;
    logic [2:0] ep;
    do_reset(1'b0);
    for (int c = 0; c < 56; c++) begin
      ep = c < 16 ? 3'd0 : c < 24 ? 3'd1 : c < 28 ? 3'd2 : c < 40 ? 3'd3 : c < 48 ? 3'd4 : c < 52 ? 3'd5 : 3'd0;
      checks++;
      if ({phase, main_light, side_light, walk} !== expect_out(ep, 1'b0)) begin
        errors++;
        $display("FAIL side_seq c=%0d: got %b want %b", c, {phase, main_light, side_light, walk}, expect_out(ep, 1'b0));
      end
      checks++;
      if ({side_pending, ped_pending} !== {c >= 3 && c < 28, 1'b0}) begin
        errors++;
        $display("FAIL side_pending c=%0d: got %b want %b", c, {side_pending, ped_pending}, {c >= 3 && c < 28, 1'b0});
      end
      side_req = c == 2;
      @(negedge clk);
    end
  endtask
  task automatic test_ped;
    logic [2:0] ep;
    logic ew;
    do_reset(1'b0);
    for (int c = 0; c < 76; c++) begin
      ep = c < 42 ? 3'd0 : c < 50 ? 3'd1 : c < 54 ? 3'd2 : c < 62 ? 3'd6 : c < 70 ? 3'd7 : 3'd0;
      ew = c >= 54 && c < 66;
      checks++;
      if ({phase, main_light, side_light, walk} !== expect_out(ep, ew)) begin
        errors++;
        $display("FAIL ped_seq c=%0d: got %b want %b", c, {phase, main_light, side_light, walk}, expect_out(ep, ew));
      end
      checks++;
      if ({side_pending, ped_pending} !== {1'b0, c >= 41 && c < 54}) begin
        errors++;
        $display("FAIL ped_pending c=%0d: got %b want %b", c, {side_pending, ped_pending}, {1'b0, c >= 41 && c < 54});
      end
`ifdef TLC_PED_COUNTDOWN_EN
      checks++;
      if (walk_count !== (c < 54 ? 8'd0 : c < 58 ? 8'd4 : c < 62 ? 8'd3 : c < 66 ? 8'd2 : c < 70 ? 8'd1 : 8'd0)) begin
        errors++;
        $display("FAIL walk_count c=%0d: got %0d", c, walk_count);
      end
`endif
      ped_req = c == 40;
      @(negedge clk);
    end
  endtask
  task automatic test_back_to_back;
    logic [2:0] ep;
    logic ew;
    do_reset(1'b0);
    for (int c = 0; c < 72; c++) begin
      ep = c < 16 ? 3'd0 : c < 24 ? 3'd1 : c < 28 ? 3'd2 : c < 40 ? 3'd3 : c < 48 ? 3'd4 :
           c < 52 ? 3'd5 : c < 60 ? 3'd6 : c < 68 ? 3'd7 : 3'd0;
      ew = c >= 52 && c < 64;
      checks++;
      if ({phase, main_light, side_light, walk} !== expect_out(ep, ew)) begin
        errors++;
        $display("FAIL both_seq c=%0d: got %b want %b", c, {phase, main_light, side_light, walk}, expect_out(ep, ew));
      end
      checks++;
      if ({side_pending, ped_pending} !== {c >= 3 && c < 28, c >= 3 && c < 52}) begin
        errors++;
        $display("FAIL both_pending c=%0d: got %b want %b", c, {side_pending, ped_pending}, {c >= 3 && c < 28, c >= 3 && c < 52});
      end
      side_req = c == 2;
      ped_req = c == 2;
      @(negedge clk);
    end
  endtask
  task automatic test_reset_mid;
    do_reset(1'b1);
    for (int c = 0; c < 30; c++) begin
      checks++;
      if (ped_pending !== 1'b0) begin
        errors++;
        $display("FAIL held_ped c=%0d: got %b want 0", c, ped_pending);
      end
      side_req = c == 2 || c == 29;
      @(negedge clk);
    end
    checks++;
    if ({phase, side_pending} !== {3'd3, 1'b1}) begin
      errors++;
      $display("FAIL pre_reset: got %b want 0111", {phase, side_pending});
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({phase, main_light, side_light, walk, side_pending, ped_pending} !== 12'b000_001_100_0_00) begin
      errors++;
      $display("FAIL mid_reset: got %b want 000001100000", {phase, main_light, side_light, walk, side_pending, ped_pending});
    end
    reset = 1'b1;
    side_req = 1'b0;
    ped_req = 1'b0;
    @(negedge clk);
  endtask
  initial begin
    test_reset_idle;
    test_side;
    test_ped;
    test_back_to_back;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
